// File: rtl/fir_decimator_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fir_decimator_if : sample-in / decimated-out bundle for fir_decimator
// Revision 1.0
// ----------------------------------------------------------------------------
interface fir_decimator_if #(
  parameter int N = 7
);
  logic         en;
  logic [N:0]   x_in;
  logic [1:0]   dec_log2;
  logic [N:0]   m_data;
  logic         m_valid;
  logic         m_ready;
  logic         ovf;
  logic         clr_ovf;

  modport master (
    output en, x_in, dec_log2, m_ready, clr_ovf,
    input  m_data, m_valid, ovf
  );

  modport slave (
    input  en, x_in, dec_log2, m_ready, clr_ovf,
    output m_data, m_valid, ovf
  );
endinterface
`default_nettype wire

// File: rtl/fir_decimator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fir_decimator : averages 2^k-sample windows, 2-entry output FIFO, sticky ovf
// Revision 1.0
// ----------------------------------------------------------------------------
module fir_decimator #(
  parameter int N          = 7,
  parameter int LOG2_M_MAX = 3
) (
  input  wire             clk,
  input  wire             rst,
  fir_decimator_if.slave  bus
);
  localparam int c_acc_w = N + 1 + LOG2_M_MAX;
  localparam int c_sum_w = c_acc_w + 1;
  localparam int c_cnt_w = (LOG2_M_MAX > 0) ? LOG2_M_MAX : 1;
  localparam logic [1:0] c_k_max = 2'(LOG2_M_MAX);

  logic [c_acc_w-1:0] r_acc;
  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_k;
  logic [N:0]         r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_occ;
  logic               r_ovf;

  logic [1:0]         w_k_req;
  logic [1:0]         w_k;
  logic [c_cnt_w:0]   w_m;
  logic               w_last;
  logic               w_done;
  logic [c_sum_w-1:0] w_round;
  logic [c_sum_w-1:0] w_sum;
  logic [N:0]         w_result;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;

  always_comb begin
    w_k_req = (bus.dec_log2 > c_k_max) ? c_k_max : bus.dec_log2;
    // The first sample of a window uses the freshly requested k, later ones the latched k.
    w_k     = (r_cnt == '0) ? w_k_req : r_k;
    w_m     = (c_cnt_w+1)'(1) << w_k;
    w_last  = ({1'b0, r_cnt} == (w_m - (c_cnt_w+1)'(1)));
    w_done  = bus.en && w_last;

    w_round = '0;
    if (w_k != 2'd0)
      w_round = c_sum_w'(1) << (w_k - 2'd1);
    w_sum    = c_sum_w'(r_acc) + c_sum_w'(bus.x_in) + w_round;
    w_result = (N+1)'(w_sum >> w_k);

    w_pop  = (r_occ != 2'd0) && bus.m_ready;
    w_push = w_done && ((r_occ != 2'd2) || w_pop);
    w_drop = w_done && (r_occ == 2'd2) && !w_pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_k   <= 2'd0;
    end else if (bus.en) begin
      if (r_cnt == '0)
        r_k <= w_k_req;
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= r_acc + c_acc_w'(bus.x_in);
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_result;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop)
        r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst)
      r_ovf <= 1'b0;
    else if (w_drop)
      r_ovf <= 1'b1;
    else if (bus.clr_ovf)
      r_ovf <= 1'b0;
  end

  assign bus.m_data  = r_mem[r_rptr];
  assign bus.m_valid = (r_occ != 2'd0);
  assign bus.ovf     = r_ovf;
endmodule
`default_nettype wire

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream stage of the 4-tap shift-add FIR filter; consumes its N+1-bit output stream.
- Averages each window of M = 2^k consecutive samples (k runtime-selectable, 0..LOG2_M_MAX).
- Emits one rounded average per window through a 2-entry output FIFO with valid/ready handshake.
- Flags results lost to sustained backpressure with a sticky overflow bit.

Parameters:
- N, 7, MSB index of sample width (samples are N+1 bits, unsigned)
- LOG2_M_MAX, 3, maximum decimation exponent (M up to 8)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  x_in is a valid filter sample this cycle
- x_in  in  N+1  filter output sample, unsigned
- dec_log2  in  2  requested decimation exponent k; values above LOG2_M_MAX clamp to LOG2_M_MAX
- m_data  out  N+1  decimated sample (FIFO head)
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts m_data when m_valid && m_ready
- ovf  out  1  sticky: a result was dropped
- clr_ovf  in  1  clears ovf

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (rst, sampled on rising clk).
- Reset state:
  - acc=0, sample count=0, latched k=0.
  - FIFO empty, m_valid=0, m_data=0, ovf=0.
  - Reset mid-window discards the partial sum; reset wins over all other inputs.
- Accumulator: width N+1+LOG2_M_MAX, unsigned.
- Window start: a sample accepted (en=1) while count=0.
  - Latches k_act = min(dec_log2, LOG2_M_MAX).
  - dec_log2 changes mid-window are ignored until the next window start.
- Window progress and completion:
  - Each accepted sample adds x_in to acc and increments count.
  - The sample with count = 2^k_act - 1 completes the window (k_act=0: every sample completes).
  - On the completing edge: result = (acc + x_in + round) >> k_act, with round = 2^(k_act-1) for k_act>0, else 0.
  - Compute with one extra guard bit; result never exceeds 2^(N+1)-1, so no saturation is needed.
  - The result is pushed into the FIFO on that same edge; acc and count return to 0.
- Latency: m_valid rises the cycle after the completing edge if the FIFO was empty.
  - No combinational bypass from x_in to m_data.
- en=0 cycles: acc, count and k_act hold.
- FIFO: 2 entries, in-order; m_data = head entry.
  - Pop on m_valid && m_ready.
  - m_data and m_valid remain stable while m_valid && !m_ready.
  - Push and pop in the same cycle:
    - FIFO full: both succeed, occupancy stays 2.
    - FIFO empty: no pop occurs, since m_valid=0; the pushed entry becomes visible next cycle.
  - Push while full without a pop: the new result is dropped, the FIFO is unchanged, and ovf is set next cycle.
- ovf: set on a drop, cleared by clr_ovf. Drop and clr_ovf in the same cycle: set wins.
- m_valid = FIFO non-empty, registered.

Test Plan:
1. dec_log2=0, m_ready=1, en=1, x_in 10,20,30 on consecutive cycles -> m_data 10,20,30, each valid one cycle after its input, m_valid high for 3 cycles.
2. dec_log2=2, x_in 1,2,3,4 -> single output 3 ((10+2)>>2); then x_in 255 ×4 -> 255; m_valid pulses once per window.
3. dec_log2=1, x_in 3,4,0,1 -> outputs 4 then 1 (round-half-up); en toggled low between samples -> same outputs, delayed accordingly.
4. dec_log2=0, m_ready=0, x_in 5,6,7 -> FIFO holds 5,6; 7 dropped; ovf=1; then m_ready=1 -> 5 then 6, m_valid falls; pulse clr_ovf -> ovf=0.
5. dec_log2=2, accept 2 samples (8,8), switch dec_log2=0, accept 8,8 -> one output 8 after the 4th sample; the next samples are then passed through individually.
6. dec_log2=2, x_in 8,8, assert rst 1 cycle, then 4,4,4,4 -> m_valid=0 until the 4th post-reset sample, output 4; no residue from the pre-reset samples.
